// File: rtl/kseq_pkg.sv
// Shared types and default widths for the sequential Karatsuba multiplier.
package kseq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_P,
    MUL_Q,
    MUL_T,
    COMBINE,
    DONE
  } kseq_state_e;

  localparam int KSEQ_N_DEF     = 32;
  localparam int KSEQ_CNT_W_DEF = 16;

endpackage

// File: rtl/kseq_mul_core.sv
// Shared unsigned W x W multiplier; KSEQ_MUL_PIPE_EN adds one output register stage.
module kseq_mul_core #(
  parameter int W = 17
) (
`ifdef KSEQ_MUL_PIPE_EN
  input  logic             clk,
  input  logic             rst,
`endif
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   prod
);

`ifdef KSEQ_MUL_PIPE_EN
  logic [2*W-1:0] prod_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_reg <= '0;
    end else begin
      prod_reg <= a * b;
    end
  end

  assign prod = prod_reg;
`else
  assign prod = a * b;
`endif

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Sequential Karatsuba NxN multiplier: three passes through one (N/2+1)-bit multiplier.
// Build option KSEQ_MUL_PIPE_EN registers the multiplier and stretches each pass to 2 cycles.
module karatsuba_seq_ctrl
  import kseq_pkg::*;
#(
  parameter int N     = KSEQ_N_DEF,
  parameter int M     = 2 * N,
  parameter int CNT_W = KSEQ_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     num1_i,
  input  logic [N-1:0]     num2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [M-1:0]     resul_o,
  input  logic             flush_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_cnt_o
);

  localparam int H = N / 2;
  localparam int W = H + 1;

  kseq_state_e      state_reg;
  logic [H-1:0]     hi1_reg, lo1_reg, hi2_reg, lo2_reg;
  logic [N-1:0]     p_reg, q_reg;
  logic [N+1:0]     t_reg;
  logic [M-1:0]     resul_reg;
  logic             in_ready_reg, out_valid_reg, busy_reg;
  logic [CNT_W-1:0] op_cnt_reg;

  logic [W-1:0]     mul_a, mul_b;
  logic [2*W-1:0]   mul_prod;
  logic             pass_done;
  logic [N+1:0]     mid;
  logic [M-1:0]     sum;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      MUL_P: begin
        mul_a = {1'b0, hi1_reg};
        mul_b = {1'b0, hi2_reg};
      end
      MUL_Q: begin
        mul_a = {1'b0, lo1_reg};
        mul_b = {1'b0, lo2_reg};
      end
      MUL_T: begin
        mul_a = {1'b0, hi1_reg} + {1'b0, lo1_reg};
        mul_b = {1'b0, hi2_reg} + {1'b0, lo2_reg};
      end
      default: ;
    endcase
  end

  kseq_mul_core #(.W(W)) u_mul (
`ifdef KSEQ_MUL_PIPE_EN
    .clk  (clk_i),
    .rst  (rst_i),
`endif
    .a    (mul_a),
    .b    (mul_b),
    .prod (mul_prod)
  );

`ifdef KSEQ_MUL_PIPE_EN
  logic sub_reg;
  assign pass_done = sub_reg;
`else
  assign pass_done = 1'b1;
`endif

  // Cross term is never negative; any carry above M bits is zero for a true product.
  assign mid = t_reg - {2'b00, p_reg} - {2'b00, q_reg};
  assign sum = (M'(p_reg) << N) + (M'(mid) << H) + M'(q_reg);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      hi1_reg       <= '0;
      lo1_reg       <= '0;
      hi2_reg       <= '0;
      lo2_reg       <= '0;
      p_reg         <= '0;
      q_reg         <= '0;
      t_reg         <= '0;
      resul_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      op_cnt_reg    <= '0;
`ifdef KSEQ_MUL_PIPE_EN
      sub_reg       <= 1'b0;
`endif
    end else if (flush_i) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef KSEQ_MUL_PIPE_EN
      sub_reg       <= 1'b0;
`endif
    end else begin
`ifdef KSEQ_MUL_PIPE_EN
      sub_reg <= (state_reg == MUL_P || state_reg == MUL_Q || state_reg == MUL_T) ? !sub_reg : 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (in_valid_i) begin
            {hi1_reg, lo1_reg} <= num1_i;
            {hi2_reg, lo2_reg} <= num2_i;
            state_reg          <= MUL_P;
            in_ready_reg       <= 1'b0;
            busy_reg           <= 1'b1;
          end
        end
        MUL_P: begin
          if (pass_done) begin
            p_reg     <= mul_prod[N-1:0];
            state_reg <= MUL_Q;
          end
        end
        MUL_Q: begin
          if (pass_done) begin
            q_reg     <= mul_prod[N-1:0];
            state_reg <= MUL_T;
          end
        end
        MUL_T: begin
          if (pass_done) begin
            t_reg     <= mul_prod;
            state_reg <= COMBINE;
          end
        end
        COMBINE: begin
          resul_reg     <= sum;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            op_cnt_reg    <= op_cnt_reg + 1'b1;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = out_valid_reg;
  assign busy_o      = busy_reg;
  assign resul_o     = resul_reg;
  assign op_cnt_o    = op_cnt_reg;

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Self-checking bench for karatsuba_seq_ctrl: vector table, random operands, and corner sequences.
module tb_karatsuba_seq_ctrl;

  localparam int N     = 32;
  localparam int M     = 64;
  localparam int CNT_W = 16;
`ifdef KSEQ_MUL_PIPE_EN
  localparam int LAT   = 7;
  localparam int EXTRA = 1;
`else
  localparam int LAT   = 4;
  localparam int EXTRA = 0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [N-1:0]     num1_i = '0;
  logic [N-1:0]     num2_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic [M-1:0]     resul_o;
  logic             flush_i = 1'b0;
  logic             busy_o;
  logic [CNT_W-1:0] op_cnt_o;

  int checks   = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  karatsuba_seq_ctrl #(.N(N), .M(M), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .num1_i      (num1_i),
    .num2_i      (num2_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .resul_o     (resul_o),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .op_cnt_o    (op_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [M-1:0] exp;
  } vec_t;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_in_ready"},  64'(in_ready_o),  64'd1);
    check({name, "_out_valid"}, 64'(out_valid_o), 64'd0);
    check({name, "_busy"},      64'(busy_o),      64'd0);
    check({name, "_resul"},     64'(resul_o),     64'd0);
    check({name, "_op_cnt"},    64'(op_cnt_o),    64'd0);
  endtask

  // One full transaction; the expected product is plain 64-bit arithmetic.
  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [M-1:0] req, input int stall);
    int cyc;
    out_ready_i = (stall == 0);
    cyc = 0;
    while (!in_ready_o && cyc < 20) begin
      step();
      cyc++;
    end
    check({name, "_in_ready"}, 64'(in_ready_o), 64'd1);
    in_valid_i = 1'b1;
    num1_i     = a;
    num2_i     = b;
    step();
    in_valid_i = 1'b0;
    cyc = 0;
    while (!out_valid_o && cyc < 30) begin
      step();
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'(LAT));
    check({name, "_resul"}, resul_o, req);
    if (stall > 0) begin
      repeat (stall) step();
      check({name, "_held"}, resul_o, req);
      out_ready_i = 1'b1;
    end
    step();
    exp_cnt = exp_cnt + 1'b1;
    check({name, "_cnt"}, 64'(op_cnt_o), 64'(exp_cnt));
    check({name, "_valid_drop"}, 64'(out_valid_o), 64'd0);
    $display("op %s a=%h b=%h resul=%h req=%h cnt=%0d", name, a, b, resul_o, req, op_cnt_o);
  endtask

  vec_t vecs [8];
  logic [M-1:0] held;
  logic [N-1:0] ra, rb;

  initial begin
    vecs[0] = '{32'd3,          32'd5,          64'd15};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
    vecs[2] = '{32'h00010000,   32'h0000FFFF,   64'h0000_0000_FFFF_0000};
    vecs[3] = '{32'h00000000,   32'hDEADBEEF,   64'd0};
    vecs[4] = '{32'h12341234,   32'h56785678,   64'h12341234 * 64'h56785678};
    vecs[5] = '{32'hFFFFFFFF,   32'h00000001,   64'h00000000FFFFFFFF};
    vecs[6] = '{32'h80008000,   32'hFFFF0000,   64'h80008000 * 64'hFFFF0000};
    vecs[7] = '{32'd7,          32'd9,          64'd63};

    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    check_reset_values("reset");

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, 0);
    end

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) rb = ra;
      run_op($sformatf("rnd%0d", i), ra, rb, 64'(ra) * 64'(rb), int'($urandom_range(0, 3)));
    end

    // Consumer stalls 10 cycles in DONE while the producer keeps offering data.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    num1_i      = 32'h0BADF00D;
    num2_i      = 32'h00C0FFEE;
    step();
    num1_i = 32'h11111111;
    num2_i = 32'h22222222;
    begin
      int cyc;
      cyc = 0;
      while (!out_valid_o && cyc < 30) begin
        step();
        cyc++;
      end
    end
    held = resul_o;
    check("stall_resul", resul_o, 64'h0BADF00D * 64'h00C0FFEE);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("stall_hold%0d", i), resul_o, 64'h0BADF00D * 64'h00C0FFEE);
      check($sformatf("stall_valid%0d", i), 64'(out_valid_o), 64'd1);
      check($sformatf("stall_rdy%0d", i), 64'(in_ready_o), 64'd0);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    exp_cnt = exp_cnt + 1'b1;
    check("stall_cnt", 64'(op_cnt_o), 64'(exp_cnt));
    step();
    check("stall_cnt_once", 64'(op_cnt_o), 64'(exp_cnt));
    check("stall_no_accept", 64'(busy_o), 64'd0);
    $display("op stall resul=%h cnt=%0d", held, op_cnt_o);

    // Flush while in MUL_Q.
    in_valid_i = 1'b1;
    num1_i     = 32'hAAAA5555;
    num2_i     = 32'h5555AAAA;
    step();
    in_valid_i = 1'b0;
    repeat (1 + EXTRA) step();
    check("flush_busy_before", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_busy",      64'(busy_o),      64'd0);
    check("flush_in_ready",  64'(in_ready_o),  64'd1);
    check("flush_out_valid", 64'(out_valid_o), 64'd0);
    check("flush_cnt",       64'(op_cnt_o),    64'(exp_cnt));
    check("flush_resul_kept", resul_o, 64'h0BADF00D * 64'h00C0FFEE);
    repeat (8) step();
    check("flush_no_valid", 64'(out_valid_o), 64'd0);
    $display("op flush cnt=%0d", op_cnt_o);
    run_op("after_flush", 32'd7, 32'd9, 64'd63, 0);

    // Flush in IDLE beats a simultaneous operand.
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    step();
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    check("idle_flush_busy", 64'(busy_o), 64'd0);
    $display("op idle_flush busy=%0d", busy_o);

    // Reset while in MUL_T.
    in_valid_i = 1'b1;
    num1_i     = 32'h12345678;
    num2_i     = 32'h9ABCDEF0;
    step();
    in_valid_i = 1'b0;
    repeat (2 + 2 * EXTRA) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    exp_cnt = '0;
    check_reset_values("rst_mul_t");
    $display("op rst_mul_t cnt=%0d", op_cnt_o);

    // Counter wrap via preload.
    force dut.op_cnt_reg = 16'hFFFE;
    step();
    release dut.op_cnt_reg;
    exp_cnt = 16'hFFFE;
    check("preload_cnt", 64'(op_cnt_o), 64'hFFFE);
    run_op("wrap_a", 32'd2, 32'd3, 64'd6, 0);
    run_op("wrap_b", 32'hFFFF, 32'hFFFF, 64'hFFFE0001, 0);
    check("wrap_zero", 64'(op_cnt_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
